// File: rtl/seg7_pkg.sv
// Shared glyph constants, display modes, converter states and helpers for the
// seg7_display_ctrl block.
package seg7_pkg;

   localparam int unsigned DIGITS  = 8;
   localparam int unsigned DATA_W  = 32;
   localparam int unsigned SEG_W   = 8;
   localparam logic [31:0] DEC_MAX = 32'd99_999_999;

   // Segment order is {a,b,c,d,e,f,g,dp}; dp is never lit.
   localparam logic [7:0] SEG_0     = 8'b1111_1100;
   localparam logic [7:0] SEG_1     = 8'b0110_0000;
   localparam logic [7:0] SEG_2     = 8'b1101_1010;
   localparam logic [7:0] SEG_3     = 8'b1111_0010;
   localparam logic [7:0] SEG_4     = 8'b0110_0110;
   localparam logic [7:0] SEG_5     = 8'b1011_0110;
   localparam logic [7:0] SEG_6     = 8'b1011_1110;
   localparam logic [7:0] SEG_7     = 8'b1110_0000;
   localparam logic [7:0] SEG_8     = 8'b1111_1110;
   localparam logic [7:0] SEG_9     = 8'b1111_0110;
   localparam logic [7:0] SEG_A     = 8'b1110_1110;
   localparam logic [7:0] SEG_B     = 8'b0011_1110;
   localparam logic [7:0] SEG_C     = 8'b1001_1100;
   localparam logic [7:0] SEG_D     = 8'b0111_1010;
   localparam logic [7:0] SEG_E     = 8'b1001_1110;
   localparam logic [7:0] SEG_F     = 8'b1000_1110;
   localparam logic [7:0] SEG_BLANK = 8'b0000_0000;
   localparam logic [7:0] SEG_DASH  = 8'b0000_0010;

   typedef enum logic [1:0] {
      MODE_HEX = 2'd0,
      MODE_DEC = 2'd1,
      MODE_OVF = 2'd2
   } disp_mode_e;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CONV = 2'd1,
      ST_LOAD = 2'd2
   } conv_state_e;

   // Hex glyph for one nibble (b and d drawn lower-case).
   function automatic logic [7:0] nibble_to_seg(input logic [3:0] nib);
      logic [7:0] seg;
      case (nib)
         4'h0:    seg = SEG_0;
         4'h1:    seg = SEG_1;
         4'h2:    seg = SEG_2;
         4'h3:    seg = SEG_3;
         4'h4:    seg = SEG_4;
         4'h5:    seg = SEG_5;
         4'h6:    seg = SEG_6;
         4'h7:    seg = SEG_7;
         4'h8:    seg = SEG_8;
         4'h9:    seg = SEG_9;
         4'hA:    seg = SEG_A;
         4'hB:    seg = SEG_B;
         4'hC:    seg = SEG_C;
         4'hD:    seg = SEG_D;
         4'hE:    seg = SEG_E;
         default: seg = SEG_F;
      endcase
      return seg;
   endfunction

   // Double-dabble correction: add 3 to every BCD nibble that is 5 or more.
   function automatic logic [31:0] bcd_adjust(input logic [31:0] bcd);
      logic [31:0] res;
      res = bcd;
      for (int i = 0; i < 8; i++) begin
         if (bcd[4*i +: 4] >= 4'd5) begin
            res[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential 32-bit binary to 8-digit BCD converter: one shift-add step per
// cycle for 32 cycles, then a single LOAD cycle that presents the result.
module bin2bcd_seq
   import seg7_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start_i,
   input  logic [31:0] bin_i,
   output logic        busy_o,
   output logic        done_o,
   output logic [31:0] bcd_o
);

   localparam int unsigned STEPS  = 32;
   localparam int unsigned STEP_W = $clog2(STEPS);

   conv_state_e       state_q;
   logic [31:0]       bin_q;
   logic [31:0]       bcd_q;
   logic [31:0]       bin_d;
   logic [31:0]       bcd_d;
   logic [STEP_W-1:0] step_q;
   logic              busy_q;
   logic              done_q;

   // One double-dabble step applied to the {bcd, bin} shift pair.
   always_comb begin
      {bcd_d, bin_d} = {bcd_adjust(bcd_q), bin_q} << 1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         bin_q   <= '0;
         bcd_q   <= '0;
         step_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               done_q <= 1'b0;
               if (start_i) begin
                  bin_q   <= bin_i;
                  bcd_q   <= '0;
                  step_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= ST_CONV;
               end
            end
            ST_CONV: begin
               bin_q  <= bin_d;
               bcd_q  <= bcd_d;
               step_q <= step_q + STEP_W'(1);
               if (step_q == STEP_W'(STEPS - 1)) begin
                  done_q  <= 1'b1;
                  state_q <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               done_q  <= 1'b0;
               busy_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;

endmodule

// File: rtl/seg7_display_ctrl.sv
// Eight-digit multiplexed 7-segment display controller: hex or unsigned decimal
// view of a 32-bit MMIO-written value, with sequential decimal conversion.
module seg7_display_ctrl
   import seg7_pkg::*;
#(
   parameter int unsigned SCAN_DIV = 100000,
   parameter bit          BLANK_LZ = 1'b1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic        wr_mode,
   input  logic [31:0] wr_data,
   output logic        busy,
   output logic [7:0]  tubSel,
   output logic [7:0]  seg_led1234,
   output logic [7:0]  seg_led5678
);

   localparam int unsigned CNT_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;

   logic             conv_start_c;
   logic             conv_busy;
   logic             conv_done;
   logic [31:0]      conv_bcd;

   logic [31:0]      disp_val_q;
   disp_mode_e       mode_q;

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [2:0]       dig_q;
   logic [2:0]       dig_d;
   logic             wrap_c;

   logic [3:0]       nib_c;
   logic             lead_zero_c;
   logic [7:0]       glyph_c;
   logic [7:0]       tub_d;
   logic [7:0]       seg_hi_d;
   logic [7:0]       seg_lo_d;
   logic [7:0]       tub_q;
   logic [7:0]       seg_hi_q;
   logic [7:0]       seg_lo_q;

   // Only in-range decimal writes accepted while idle start a conversion.
   assign conv_start_c = wr_en && wr_mode && !conv_busy && (wr_data <= DEC_MAX);

   bin2bcd_seq u_bin2bcd (
      .clk     (clk),
      .reset   (reset),
      .start_i (conv_start_c),
      .bin_i   (wr_data),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd)
   );

   // Displayed value and mode; writes arriving while converting are dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         disp_val_q <= '0;
         mode_q     <= MODE_HEX;
      end else if (conv_done) begin
         disp_val_q <= conv_bcd;
         mode_q     <= MODE_DEC;
      end else if (wr_en && !conv_busy) begin
         if (!wr_mode) begin
            disp_val_q <= wr_data;
            mode_q     <= MODE_HEX;
         end else if (wr_data > DEC_MAX) begin
            mode_q     <= MODE_OVF;
         end
      end
   end

   // Scan timing and the glyph for the digit that becomes active on a wrap.
   always_comb begin
      wrap_c = (cnt_q == CNT_W'(SCAN_DIV - 1));
      cnt_d  = wrap_c ? '0 : cnt_q + CNT_W'(1);
      dig_d  = wrap_c ? dig_q + 3'd1 : dig_q;

      nib_c       = disp_val_q[{dig_d, 2'b00} +: 4];
      lead_zero_c = (dig_d != 3'd0) && ((disp_val_q >> {dig_d, 2'b00}) == 32'd0);

      case (mode_q)
         MODE_HEX: glyph_c = nibble_to_seg(nib_c);
         MODE_DEC: glyph_c = (BLANK_LZ && lead_zero_c) ? SEG_BLANK : nibble_to_seg(nib_c);
         default:  glyph_c = SEG_DASH;
      endcase

      tub_d    = 8'b0000_0001 << dig_d;
      seg_hi_d = dig_d[2] ? glyph_c : SEG_BLANK;
      seg_lo_d = dig_d[2] ? SEG_BLANK : glyph_c;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q    <= '0;
         dig_q    <= '0;
         tub_q    <= 8'b0000_0001;
         seg_hi_q <= SEG_BLANK;
         seg_lo_q <= SEG_0;
      end else begin
         cnt_q <= cnt_d;
         if (wrap_c) begin
            dig_q    <= dig_d;
            tub_q    <= tub_d;
            seg_hi_q <= seg_hi_d;
            seg_lo_q <= seg_lo_d;
         end
      end
   end

   assign busy        = conv_busy;
   assign tubSel      = tub_q;
   assign seg_led1234 = seg_hi_q;
   assign seg_led5678 = seg_lo_q;

endmodule

// File: tb/tb_seg7_display_ctrl.sv
// Scoreboard bench for seg7_display_ctrl: stimulus queues expected frames and
// busy windows from a decimal/hex arithmetic model; a monitor checks each scan.
module tb_seg7_display_ctrl;

   localparam int unsigned SCAN = 4;

   localparam logic [7:0] GLYPH [16] = '{
      8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6, 8'hBE, 8'hE0,
      8'hFE, 8'hF6, 8'hEE, 8'h3E, 8'h9C, 8'h7A, 8'h9E, 8'h8E
   };

   typedef struct {
      int          e;
      logic [63:0] g;
   } frame_t;

   logic        clk;
   logic        reset;
   logic        wr_en;
   logic        wr_mode;
   logic [31:0] wr_data;
   logic        busy;
   logic [7:0]  tubSel;
   logic [7:0]  seg_led1234;
   logic [7:0]  seg_led5678;

   int checks;
   int failures;
   int cyc;
   int rst_edge;
   int busy_end;

   frame_t frame_q [$];
   int     win_q   [$];

   seg7_display_ctrl #(
      .SCAN_DIV (SCAN),
      .BLANK_LZ (1'b1)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_mode     (wr_mode),
      .wr_data     (wr_data),
      .busy        (busy),
      .tubSel      (tubSel),
      .seg_led1234 (seg_led1234),
      .seg_led5678 (seg_led5678)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (reset) rst_edge = cyc;
   end

   // Expected eight glyphs, digit k in bits [8k+7:8k]; mode 0 hex, 1 decimal, 2 overflow.
   function automatic logic [63:0] frame_of(input int mode, input logic [31:0] v);
      logic [63:0] f;
      longint      lv;
      longint      p;
      int          dg;
      f  = '0;
      lv = longint'({32'd0, v});
      p  = 1;
      for (int k = 0; k < 8; k++) begin
         if (mode == 0) begin
            f[8*k +: 8] = GLYPH[v[4*k +: 4]];
         end else if (mode == 2) begin
            f[8*k +: 8] = 8'h02;
         end else begin
            dg = int'((lv / p) % 10);
            f[8*k +: 8] = (k > 0 && lv < p) ? 8'h00 : GLYPH[dg];
         end
         p = p * 10;
      end
      return f;
   endfunction

   task automatic check8(input string nm, input int at, input logic [7:0] got, input logic [7:0] exp);
      checks = checks + 1;
      if (got !== exp) begin
         failures = failures + 1;
         $display("FAIL %s cyc=%0d got=%h exp=%h", nm, at, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue a one-cycle write and record its expected effect.
   task automatic do_write(input bit m, input logic [31:0] d);
      int     c;
      frame_t fr;
      c       = cyc + 1;
      wr_en   = 1'b1;
      wr_mode = m;
      wr_data = d;
      if (c > busy_end) begin
         if (!m) begin
            fr.e = c;
            fr.g = frame_of(0, d);
            frame_q.push_back(fr);
         end else if (d > 32'd99_999_999) begin
            fr.e = c;
            fr.g = frame_of(2, d);
            frame_q.push_back(fr);
         end else begin
            fr.e = c + 33;
            fr.g = frame_of(1, d);
            frame_q.push_back(fr);
            win_q.push_back(c);
            busy_end = c + 33;
         end
      end
      tick(1);
      wr_en = 1'b0;
   endtask

   // Monitor: scan position from cycles since reset, display from the frame queue.
   int          seen_rst;
   int          cur_n;
   logic [63:0] cur_frame;
   int          m_d;
   int          m_phase;
   int          m_k;
   int          m_w;
   logic [7:0]  m_g;

   always @(negedge clk) begin
      if (rst_edge >= 0) begin
         if (rst_edge != seen_rst) begin
            seen_rst  = rst_edge;
            frame_q.delete();
            win_q.delete();
            cur_frame = frame_of(0, 32'd0);
            cur_n     = -1000;
         end
         m_d     = cyc - rst_edge;
         m_phase = m_d % SCAN;
         m_k     = (m_d / SCAN) % 8;
         m_w     = cyc - m_phase;
         while (frame_q.size() > 0 && frame_q[0].e < m_w) begin
            cur_frame = frame_q[0].g;
            void'(frame_q.pop_front());
         end
         while (win_q.size() > 0 && win_q[0] <= cyc) cur_n = win_q.pop_front();
         if (cyc != cur_n) begin
            check8("busy", cyc, {7'd0, busy},
                   {7'd0, (cyc >= cur_n + 1 && cyc <= cur_n + 32)});
         end
         if (m_phase == 0) begin
            m_g = cur_frame[8*m_k +: 8];
            check8("tubSel", cyc, tubSel, 8'h01 << m_k);
            check8("seg_led5678", cyc, seg_led5678, (m_k < 4) ? m_g : 8'h00);
            check8("seg_led1234", cyc, seg_led1234, (m_k < 4) ? 8'h00 : m_g);
         end
      end
   end

   initial begin
      int          sel;
      logic [31:0] d;
      bit          m;
      checks   = 0;
      failures = 0;
      cyc      = 0;
      rst_edge = -1;
      seen_rst = -1;
      cur_n    = -1000;
      busy_end = -100;
      reset    = 1'b1;
      wr_en    = 1'b0;
      wr_mode  = 1'b0;
      wr_data  = '0;
      tick(2);
      reset = 1'b0;
      tick(40);

      do_write(1'b0, 32'h1234_ABCD);
      tick(40);
      do_write(1'b1, 32'd305);
      tick(75);
      do_write(1'b1, 32'd99_999_999);
      tick(75);
      do_write(1'b1, 32'd100_000_000);
      tick(40);

      // Hex write ten cycles into a conversion must be dropped.
      do_write(1'b1, 32'd12_345_678);
      tick(9);
      do_write(1'b0, 32'hFFFF_FFFF);
      tick(70);

      // Reset fifteen cycles into a conversion aborts it.
      do_write(1'b1, 32'd4321);
      tick(14);
      reset = 1'b1;
      tick(1);
      reset    = 1'b0;
      busy_end = -100;
      tick(40);

      for (int i = 0; i < 40; i++) begin
         sel = int'($urandom_range(0, 4));
         case (sel)
            0:       d = $urandom;
            1:       d = $urandom % 32'd100_000_000;
            2:       d = 32'($urandom_range(0, 999));
            3:       d = 32'd100_000_000 + 32'($urandom_range(0, 5));
            default: d = 32'd99_999_999 - 32'($urandom_range(0, 5));
         endcase
         m = 1'($urandom_range(0, 1));
         do_write(m, d);
         tick(int'($urandom_range(1, 80)));
      end
      tick(80);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/seg7_display_ctrl.md
Name: seg7_display_ctrl

Overview:
Downstream display stage of the CPU. It accepts a 32-bit value written by the CPU's MMIO store path and shows it on the board's eight 7-segment digits as either 8 hex digits or an unsigned decimal number. Decimal conversion is sequential (double-dabble). It drives tubSel, seg_led1234 and seg_led5678 directly to the pins.

Parameters:
SCAN_DIV, 100000, clk cycles per digit dwell (1 kHz/digit at 100 MHz); must be >= 2; the bench uses 4
BLANK_LZ, 1, 1 = leading-zero blanking in decimal mode; hex mode never blanks

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
wr_en  in  1  one-cycle write strobe from the MMIO decoder
wr_mode  in  1  0 = hex, 1 = decimal; sampled with wr_en
wr_data  in  32  value to display; sampled with wr_en
busy  out  1  decimal conversion in progress; writes are ignored while high
tubSel  out  8  one-hot digit select, active-high; bit k = digit k, digit 7 leftmost
seg_led1234  out  8  segments for digits 7..4, {a,b,c,d,e,f,g,dp}, active-high
seg_led5678  out  8  segments for digits 3..0, same encoding

Behaviour:
- Reset (synchronous, active-high):
  - disp_val = 0, mode = hex, FSM = IDLE, busy = 0.
  - scan counter = 0, digit index = 0.
  - Outputs: tubSel = 8'b0000_0001, seg_led5678 = 8'b1111_1100 ('0'), seg_led1234 = 0.
- All outputs are registered.
- FSM states: IDLE, CONV, LOAD.
  - IDLE, wr_en, wr_mode = 0: disp_val <= wr_data, mode <= hex. Visible on the next scan update; FSM stays IDLE.
  - IDLE, wr_en, wr_mode = 1, wr_data > 99_999_999: mode <= overflow. All digits show '-' (8'b0000_0010). No conversion; busy stays 0.
  - IDLE, wr_en, wr_mode = 1, otherwise: latch wr_data into the shift register, clear the 32-bit BCD accumulator, go to CONV.
  - CONV: one double-dabble step per cycle (add 3 to any BCD nibble >= 5, then shift left 1), 32 steps. After the 32nd step go to LOAD.
  - LOAD: disp_val <= BCD, mode <= dec, go to IDLE.
- busy timing: high in CONV and LOAD. For wr_en at edge N, busy = 1 from N+1 through N+33. The new digits commit at edge N+33.
- wr_en while busy is dropped silently; the previously displayed value stays on screen until LOAD.
- Scanning:
  - The counter counts 0..SCAN_DIV-1. On wrap, the digit index increments 7 -> 0 wrap-around.
  - The output registers update on the same edge.
  - Exactly one tubSel bit is high at all times.
  - The active group carries the pattern. The inactive group outputs 8'h00.
- Digit k nibble = disp_val[4k+3:4k].
  - Hex mode: glyphs 0-F (b and d lower-case).
  - Decimal mode: digits 0-9 only.
- Leading-zero blanking (decimal mode, BLANK_LZ = 1): digit k is blanked (8'h00) if it and all digits above it are 0. Digit 0 always shows.
- dp is always 0.
- Reset mid-conversion aborts: the display returns to the reset state and no pending write survives.
- A simultaneous wr_en and scan wrap are independent. The scan uses the disp_val value present at that edge.

Decomposition:
- Package seg7_pkg holds:
  - SEG_* glyph constants (0-F, BLANK, DASH)
  - the mode enum (HEX, DEC, OVF)
  - the FSM state enum
  - the function nibble_to_seg
- One sub-module, bin2bcd_seq, owns the CONV/LOAD shift-add datapath.
  - Interface: start, bin[31:0], busy, done, bcd[31:0].
- The top module keeps the write decode, disp_val, the scan counter and the output registers.

Test Plan:
- Reset for 2 cycles, SCAN_DIV = 4 -> tubSel = 01, seg_led5678 = FC, seg_led1234 = 00. tubSel rotates one-hot every 4 cycles: 01, 02, ... 80, 01.
- Hex write 32'h1234_ABCD -> busy stays 0. Over one full scan, digit 0 = 'd' (8'b0111_1010) and digit 7 = '1' (8'b0110_0000). Active-group check: digits 0..3 on seg_led5678 only, digits 4..7 on seg_led1234 only.
- Decimal write 32'd305 at edge N -> busy rises at N+1 and falls after N+33. Digits 2,1,0 = '3','0','5'; digits 7..3 blank. Digit 1 shows '0' (not blanked).
- Decimal write 99_999_999 -> all eight digits '9'. Decimal write 100_000_000 -> all digits DASH, busy never asserts.
- wr_en with hex 32'hFFFF_FFFF at N+10 during a decimal conversion -> write ignored; the decimal result is displayed after LOAD.
- Assert reset at N+15 of a conversion -> the next cycle shows busy = 0, tubSel = 01, seg_led5678 = FC, and hex mode is active.
